// File: rtl/overlay_streamer.sv
// overlay_streamer: rewinds to base_addr at each frame start, prefetches packed RGBA words into a FIFO
// and unpacks one pixel per active ce_pix. Optional OVERLAY_PREMUL_EN adds an alpha-premultiply stage.
module overlay_streamer #(
  parameter int CH_BITS    = 4,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              ce_pix,
  input  logic              hblank,
  input  logic              vblank,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [WORD_W-1:0] mem_data,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic [7:0]        pix_a,
  output logic              underflow
);
  localparam int PIX_W = 4 * CH_BITS;
  localparam int PPW   = WORD_W / PIX_W;
  localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PPW - 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN} state_t;

  state_t              r_state;
  logic                r_vblank_d;
  logic                r_drop;
  logic                r_mem_req;
  logic                r_underflow;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [WORD_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [IDX_W-1:0]    r_idx;
  logic [7:0]          r_px_r, r_px_g, r_px_b, r_px_a;

  logic                w_vblank_rise, w_active, w_empty, w_run, w_push, w_pop, w_issue;
  logic [WORD_W-1:0]   w_head_word;
  logic [PIX_W-1:0]    w_pix_arr [PPW];
  logic [PIX_W-1:0]    w_head_pix;

  // Replicate the channel MSB-first until 8 bits are filled (full scale maps to 0xFF).
  function automatic logic [7:0] f_expand(input logic [CH_BITS-1:0] c);
    logic [7:0] v;
    for (int i = 0; i < 8; i++)
      v[7-i] = c[CH_BITS-1-(i % CH_BITS)];
    return v;
  endfunction

  assign w_vblank_rise = vblank & ~r_vblank_d;
  assign w_active      = ce_pix & ~hblank & ~vblank;
  assign w_empty       = (r_count == '0);
  assign w_run         = enable & (r_state == S_RUN);
  assign w_push        = w_run & r_mem_req & mem_valid & ~r_drop;
  assign w_pop         = w_run & w_active & ~w_empty & (r_idx == LAST_IDX);
  // Only one request in flight, so count + outstanding < depth reduces to count < depth.
  assign w_issue       = w_run & ~w_vblank_rise & ~r_mem_req & (r_count < DEPTH_C);

  assign w_head_word = r_fifo[r_rd_ptr];
  generate
    for (genvar gi = 0; gi < PPW; gi++) begin : g_unpack
      assign w_pix_arr[gi] = w_head_word[gi*PIX_W +: PIX_W];
    end
  endgenerate
  assign w_head_pix = w_pix_arr[r_idx];

  always_ff @(posedge clk_sys) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= mem_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_vblank_d  <= 1'b0;
      r_drop      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_rd_addr   <= '0;
      r_underflow <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_px_r      <= '0;
      r_px_g      <= '0;
      r_px_b      <= '0;
      r_px_a      <= '0;
    end else begin
      r_vblank_d <= vblank;

      if (r_mem_req && mem_valid) begin
        r_mem_req <= 1'b0;
        r_drop    <= 1'b0;
      end else if (w_issue) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= r_rd_addr;
        r_rd_addr  <= r_rd_addr + ADDR_W'(1);
      end

      if (!enable) begin
        r_state     <= S_IDLE;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_idx       <= '0;
        r_underflow <= 1'b0;
        r_px_r      <= '0;
        r_px_g      <= '0;
        r_px_b      <= '0;
        r_px_a      <= '0;
        if (r_mem_req && !mem_valid)
          r_drop <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_px_r <= '0;
            r_px_g <= '0;
            r_px_b <= '0;
            r_px_a <= '0;
            if (w_vblank_rise)
              r_state <= S_FLUSH;
          end
          S_FLUSH: begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_rd_addr   <= base_addr;
            r_underflow <= 1'b0;
            r_state     <= S_RUN;
            if (ce_pix) begin
              r_px_r <= '0;
              r_px_g <= '0;
              r_px_b <= '0;
              r_px_a <= '0;
            end
          end
          default: begin
            if (w_vblank_rise) begin
              r_state <= S_FLUSH;
              if (r_mem_req && !mem_valid)
                r_drop <= 1'b1;
            end
            if (w_push)
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
              r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
              2'b10:   r_count <= r_count + CNT_W'(1);
              2'b01:   r_count <= r_count - CNT_W'(1);
              default: r_count <= r_count;
            endcase
            if (ce_pix) begin
              if (w_active && !w_empty) begin
                r_px_r <= f_expand(w_head_pix[0*CH_BITS +: CH_BITS]);
                r_px_g <= f_expand(w_head_pix[1*CH_BITS +: CH_BITS]);
                r_px_b <= f_expand(w_head_pix[2*CH_BITS +: CH_BITS]);
                r_px_a <= f_expand(w_head_pix[3*CH_BITS +: CH_BITS]);
                r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
              end else begin
                // Empty FIFO stalls the image rather than skipping pixels.
                r_px_r <= '0;
                r_px_g <= '0;
                r_px_b <= '0;
                r_px_a <= '0;
                if (w_active)
                  r_underflow <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign underflow = r_underflow;

`ifdef OVERLAY_PREMUL_EN
  localparam int PM_W = 9 + CH_BITS;
  logic [7:0]       r_pm_r, r_pm_g, r_pm_b, r_pm_a;
  logic [CH_BITS:0] w_alpha1;

  // The raw alpha is the top CH_BITS of its expansion, so no separate copy is kept.
  assign w_alpha1 = {1'b0, r_px_a[7 -: CH_BITS]} + (CH_BITS+1)'(1);

  function automatic logic [7:0] f_premul(input logic [7:0] c, input logic [CH_BITS:0] a1);
    logic [PM_W-1:0] p;
    p = PM_W'(c) * PM_W'(a1);
    return p[CH_BITS +: 8];
  endfunction

  always_ff @(posedge clk_sys) begin
    if (reset || !enable) begin
      r_pm_r <= '0;
      r_pm_g <= '0;
      r_pm_b <= '0;
      r_pm_a <= '0;
    end else begin
      r_pm_r <= f_premul(r_px_r, w_alpha1);
      r_pm_g <= f_premul(r_px_g, w_alpha1);
      r_pm_b <= f_premul(r_px_b, w_alpha1);
      r_pm_a <= r_px_a;
    end
  end

  assign pix_r = r_pm_r;
  assign pix_g = r_pm_g;
  assign pix_b = r_pm_b;
  assign pix_a = r_pm_a;
`else
  assign pix_r = r_px_r;
  assign pix_g = r_px_g;
  assign pix_b = r_px_b;
  assign pix_a = r_px_a;
`endif

endmodule
